spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per transfer (range 2..32).
REQ-002 SHALL have parameter HALF_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-003 SHALL have parameter CPOL, default 0, sclk idle level.
REQ-004 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 tx_valid  input  1  transfer request.
REQ-009 tx_data  input  DATA_WIDTH  word to transmit.
REQ-010 tx_ready  output  1  controller accepts a request this cycle.
REQ-011 rx_valid  output  1  one-cycle pulse: rx_data valid.
REQ-012 rx_data  output  DATA_WIDTH  received word; held until next rx_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 sclk  output  1  SPI serial clock (registered).
REQ-015 ss_n  output  1  active-low slave select (registered).
REQ-016 mosi  output  1  serial data out (registered).
REQ-017 miso  input  1  serial data in.

Function
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-019 Handshake: a request is accepted on a cycle with tx_valid && tx_ready; tx_ready SHALL be high only in IDLE.
REQ-020 On acceptance, SHALL latch tx_data into the shift register and enter SETUP next cycle with ss_n=0 and mosi = first bit (CPHA=0) or the previous mosi value held (CPHA=1).
REQ-021 SETUP SHALL last HALF_DIV cycles with sclk=CPOL, then enter SHIFT.
REQ-022 SHIFT SHALL produce exactly DATA_WIDTH sclk pulses; each level SHALL last HALF_DIV cycles; the leading edge toggles sclk away from CPOL.
REQ-023 CPHA=0: miso SHALL be sampled on the leading edge; mosi SHALL update to the next bit on each trailing edge except the last.
REQ-024 CPHA=1: mosi SHALL update to the next bit on each leading edge (first leading edge drives bit 0 of the sequence); miso SHALL be sampled on the trailing edge.
REQ-025 Sampling: miso SHALL be captured on the same clk edge that registers the sampling sclk transition.
REQ-026 After the final trailing edge (sclk back at CPOL), SHALL enter HOLD for HALF_DIV cycles with ss_n=0.
REQ-027 At HOLD exit, ss_n SHALL go 1, rx_data SHALL load the assembled word, and rx_valid SHALL pulse for exactly that one cycle; state enters GAP.
REQ-028 GAP SHALL last HALF_DIV cycles (ss_n=1, tx_ready=0), then enter IDLE.
REQ-029 ss_n low duration SHALL be exactly (2*DATA_WIDTH+2)*HALF_DIV clk cycles; acceptance to rx_valid latency SHALL be that value + 1.
REQ-030 Received bits SHALL assemble in the same order as transmitted (MSB_FIRST governs both directions).
REQ-031 tx_valid/tx_data changes while busy SHALL be ignored; no queuing.
REQ-032 tx_valid held high continuously SHALL yield back-to-back transfers separated by GAP plus one IDLE cycle.
REQ-033 Outside IDLE-to-GAP activity, sclk SHALL equal CPOL; mosi SHALL hold its last value when ss_n=1.

Reset
REQ-034 While rst=1, regardless of state: IDLE, sclk=CPOL, ss_n=1, mosi=0, tx_ready=1 (IDLE), rx_valid=0, rx_data=0, busy=0, counters=0.
REQ-035 rst asserted mid-transfer SHALL abort without an rx_valid pulse; ss_n SHALL rise asynchronously.

Verification
REQ-036 Mode 0, DATA_WIDTH=8, HALF_DIV=2: send 0xA5, slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 on rising edges; rx_data=0x3C; ss_n low 36 cycles; rx_valid at cycle 37 after acceptance.
REQ-037 CPOL=1, CPHA=1, send 0x81, slave returns 0xFF -> sclk idle high; 8 pulses; mosi valid at each rising (trailing) edge; rx_data=0xFF.
REQ-038 MSB_FIRST=0, send 0x01 -> first mosi bit 1, remaining 7 bits 0; loopback miso=mosi gives rx_data=0x01.
REQ-039 tx_valid held high with 0x11 then 0x22 -> two transfers; ss_n high exactly HALF_DIV+1 cycles between them; two rx_valid pulses.
REQ-040 rst pulsed during 4th sclk pulse -> ss_n=1, sclk=CPOL immediately; no rx_valid; next request completes normally.
REQ-041 HALF_DIV=1, send 0xF0 in loopback -> sclk period 2 clk cycles; rx_data=0xF0; ss_n low 18 cycles.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master: one DATA_WIDTH-bit full-duplex transfer per accepted request,
// programmable sclk half-period, clock polarity/phase and bit order.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int HALF_DIV   = 2,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  ss_n,
  output logic                  mosi,
  input  logic                  miso
);
  // Handshake: a request transfers on a cycle where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and tx_valid/tx_data are ignored otherwise.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic MSB       = (MSB_FIRST != 0);
  localparam logic PHASE1    = (CPHA != 0);

  state_t state, next_state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;

  logic phase_done, last_edge, leading;
  logic first_bit, tx_head, tx_next_head;
  logic [DATA_WIDTH-1:0] tx_shifted, rx_next;

  assign phase_done = (div_cnt == DIV_LAST);
  assign last_edge  = (edge_cnt == EDGE_LAST);
  // Even edge indices move sclk away from idle, odd ones bring it back.
  assign leading    = ~edge_cnt[0];

  assign first_bit    = MSB ? tx_data[DATA_WIDTH-1] : tx_data[0];
  assign tx_head      = MSB ? tx_sr[DATA_WIDTH-1] : tx_sr[0];
  assign tx_next_head = MSB ? tx_sr[DATA_WIDTH-2] : tx_sr[1];
  assign tx_shifted   = MSB ? {tx_sr[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sr[DATA_WIDTH-1:1]};
  assign rx_next      = MSB ? {rx_sr[DATA_WIDTH-2:0], miso} : {miso, rx_sr[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (tx_valid) next_state = SETUP;
      SETUP:   if (phase_done) next_state = SHIFT;
      SHIFT:   if (phase_done && last_edge) next_state = HOLD;
      HOLD:    if (phase_done) next_state = GAP;
      GAP:     if (phase_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sclk     <= SCLK_IDLE;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || phase_done) div_cnt <= '0;
      else                             div_cnt <= div_cnt + 1'b1;
      if (state != SHIFT)  edge_cnt <= '0;
      else if (phase_done) edge_cnt <= edge_cnt + 1'b1;

      unique case (state)
        IDLE: if (tx_valid) begin
          tx_sr <= tx_data;
          rx_sr <= '0;
          ss_n  <= 1'b0;
          if (!PHASE1) mosi <= first_bit;
        end
        SHIFT: if (phase_done) begin
          sclk <= ~sclk;
          // miso is captured on the clk edge that registers the sampling sclk edge.
          if (leading) begin
            if (!PHASE1) rx_sr <= rx_next;
            else begin
              mosi  <= tx_head;
              tx_sr <= tx_shifted;
            end
          end else begin
            if (PHASE1) rx_sr <= rx_next;
            else if (!last_edge) begin
              mosi  <= tx_next_head;
              tx_sr <= tx_shifted;
            end
          end
        end
        HOLD: if (phase_done) begin
          ss_n     <= 1'b1;
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: four parameterisations sharing one clock,
// a serial slave model on instance 0, loopback on instances 2 and 3.
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      tx_valid = '0;
  logic [3:0][7:0] tx_data  = '0;
  logic [3:0]      tx_ready, rx_valid, busy, sclk, ss_n, mosi, miso;
  logic [3:0][7:0] rx_data;

  int checks   = 0;
  int failures = 0;

  spi_master_ctrl #(.DATA_WIDTH(8), .HALF_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
    .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .busy(busy[0]), .sclk(sclk[0]), .ss_n(ss_n[0]),
    .mosi(mosi[0]), .miso(miso[0]));
  spi_master_ctrl #(.DATA_WIDTH(8), .HALF_DIV(2), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
    .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .busy(busy[1]), .sclk(sclk[1]), .ss_n(ss_n[1]),
    .mosi(mosi[1]), .miso(miso[1]));
  spi_master_ctrl #(.DATA_WIDTH(8), .HALF_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
    .rx_valid(rx_valid[2]), .rx_data(rx_data[2]), .busy(busy[2]), .sclk(sclk[2]), .ss_n(ss_n[2]),
    .mosi(mosi[2]), .miso(miso[2]));
  spi_master_ctrl #(.DATA_WIDTH(8), .HALF_DIV(1), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[3]), .tx_data(tx_data[3]), .tx_ready(tx_ready[3]),
    .rx_valid(rx_valid[3]), .rx_data(rx_data[3]), .busy(busy[3]), .sclk(sclk[3]), .ss_n(ss_n[3]),
    .mosi(mosi[3]), .miso(miso[3]));

  // Slave for u0 (mode 0, MSB first): presents a bit, advances on each sclk fall.
  logic [7:0] slave_word = 8'h00;
  int bitcnt = 0;
  assign miso[0] = (bitcnt < 8) ? slave_word[3'(7 - bitcnt)] : 1'b0;
  assign miso[1] = 1'b1;
  assign miso[2] = mosi[2];
  assign miso[3] = mosi[3];

  // Mosi captured on every rising sclk; falling sclk counted on u1.
  logic [3:0] sclk_q = '0;
  logic [7:0] cap0 = '0, cap1 = '0, cap2 = '0;
  int falls1 = 0;
  always @(negedge clk) begin
    if (ss_n[0]) bitcnt <= 0;
    else if (sclk_q[0] && !sclk[0]) bitcnt <= bitcnt + 1;
    if (!sclk_q[0] && sclk[0]) cap0 <= {cap0[6:0], mosi[0]};
    if (!sclk_q[1] && sclk[1]) cap1 <= {cap1[6:0], mosi[1]};
    if (!sclk_q[2] && sclk[2]) cap2 <= {mosi[2], cap2[7:1]};
    if (sclk_q[1] && !sclk[1]) falls1 <= falls1 + 1;
    sclk_q <= sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on instance s; lat counts the accepting edge as cycle 1.
  task automatic xfer(input int s, input logic [7:0] d, output logic [7:0] rx,
                      output int lat, output int low, output int hi);
    @(negedge clk);
    tx_valid[s] = 1'b1;
    tx_data[s]  = d;
    @(posedge clk); #1;
    tx_valid[s] = 1'b0;
    tx_data[s]  = ~d;
    lat = 1;
    low = (ss_n[s] == 1'b0) ? 1 : 0;
    hi  = (sclk[s] == 1'b1) ? 1 : 0;
    while (!rx_valid[s] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!ss_n[s]) low++;
      if (sclk[s]) hi++;
    end
    rx = rx_data[s];
  endtask

  logic [7:0] rx;
  int lat, low, hi, p, cyc, n_rx, gap, rises;
  logic counting, switched, prev;
  logic [7:0] rx_got [2];
  logic [7:0] cap_got [2];

  initial begin
    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(ss_n[0]), 32'd1);
    check("rst_sclk0", 32'(sclk[0]), 32'd0);
    check("rst_sclk1_cpol1", 32'(sclk[1]), 32'd1);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check("rst_rx_data", 32'(rx_data[0]), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Mode 0: send A5, slave returns 3C.
    slave_word = 8'h3C;
    xfer(0, 8'hA5, rx, lat, low, hi);
    check("m0_rx_data", 32'(rx), 32'h3C);
    check("m0_latency", lat, 37);
    check("m0_ss_low", low, 36);
    check("m0_sclk_high_cycles", hi, 16);
    check("m0_mosi_bits", 32'(cap0), 32'hA5);
    check("m0_gap_ss_n", 32'(ss_n[0]), 32'd1);
    check("m0_gap_tx_ready", 32'(tx_ready[0]), 32'd0);
    check("m0_gap_busy", 32'(busy[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("m0_idle_tx_ready", 32'(tx_ready[0]), 32'd1);
    check("m0_idle_busy", 32'(busy[0]), 32'd0);
    check("m0_idle_sclk", 32'(sclk[0]), 32'd0);
    check("m0_mosi_held", 32'(mosi[0]), 32'd1);
    check("m0_rx_data_held", 32'(rx_data[0]), 32'h3C);
    check("m0_rx_valid_pulse", 32'(rx_valid[0]), 32'd0);

    // CPOL=1, CPHA=1: send 81, slave returns FF.
    p = falls1;
    xfer(1, 8'h81, rx, lat, low, hi);
    check("m3_rx_data", 32'(rx), 32'hFF);
    check("m3_latency", lat, 37);
    check("m3_mosi_at_rising", 32'(cap1), 32'h81);
    check("m3_pulses", falls1 - p, 8);
    check("m3_sclk_idle_high", 32'(sclk[1]), 32'd1);

    // LSB first loopback: send 01.
    xfer(2, 8'h01, rx, lat, low, hi);
    check("lsb_rx_data", 32'(rx), 32'h01);
    check("lsb_mosi_bits", 32'(cap2), 32'h01);

    // HALF_DIV=1 loopback: send F0.
    xfer(3, 8'hF0, rx, lat, low, hi);
    check("hd1_rx_data", 32'(rx), 32'hF0);
    check("hd1_ss_low", low, 18);
    check("hd1_latency", lat, 19);
    check("hd1_sclk_high_cycles", hi, 8);

    // Back-to-back with tx_valid held; data changed while busy must not corrupt 11.
    slave_word = 8'h5A;
    n_rx = 0; gap = 0; counting = 1'b0; switched = 1'b0;
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h11;
    for (cyc = 0; cyc < 200 && n_rx < 2; cyc++) begin
      @(posedge clk); #1;
      if (busy[0] && !switched) begin
        tx_data[0] = 8'h22;
        switched = 1'b1;
      end
      if (rx_valid[0]) begin
        rx_got[n_rx]  = rx_data[0];
        cap_got[n_rx] = cap0;
        n_rx++;
        counting = (n_rx == 1);
        if (n_rx == 2) tx_valid[0] = 1'b0;
      end
      if (counting) begin
        if (ss_n[0]) gap++;
        else counting = 1'b0;
      end
    end
    check("b2b_rx_count", n_rx, 2);
    check("b2b_ss_high_gap", gap, 3);
    if (n_rx == 2) begin
      check("b2b_rx0", 32'(rx_got[0]), 32'h5A);
      check("b2b_rx1", 32'(rx_got[1]), 32'h5A);
      check("b2b_mosi0", 32'(cap_got[0]), 32'h11);
      check("b2b_mosi1", 32'(cap_got[1]), 32'h22);
    end
    repeat (5) @(posedge clk);
    #1;
    check("b2b_no_third", 32'(busy[0]), 32'd0);

    // Reset during the 4th sclk pulse aborts without rx_valid.
    slave_word = 8'hFF;
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h33;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    rises = 0; prev = sclk[0];
    for (cyc = 0; cyc < 100 && rises < 4; cyc++) begin
      @(posedge clk); #1;
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
    end
    check("abort_found_pulse4", rises, 4);
    #2 rst = 1'b1;
    #1;
    check("abort_ss_n", 32'(ss_n[0]), 32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_tx_ready", 32'(tx_ready[0]), 32'd1);
    @(negedge clk) rst = 1'b0;
    n_rx = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (rx_valid[0]) n_rx++;
    end
    check("abort_no_rx_valid", n_rx, 0);

    // Normal transfer after the abort.
    slave_word = 8'h96;
    xfer(0, 8'hC6, rx, lat, low, hi);
    check("post_rx_data", 32'(rx), 32'h96);
    check("post_latency", lat, 37);
    check("post_mosi_bits", 32'(cap0), 32'hC6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
